// File: rtl/vend_pkg.sv
// Shared types and constants for the ticket vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_DISPENSE
    } state_t;

    localparam int COIN_1  = 1;
    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;

    // Widest packed fee table the slice helper accepts (N_TICKETS * CREDIT_W).
    localparam int TBL_MAX_W = 512;

    function automatic logic [31:0] fee_slice(input logic [TBL_MAX_W-1:0] tbl,
                                              input int unsigned idx,
                                              input int unsigned w);
        logic [TBL_MAX_W-1:0] shifted;
        logic [31:0]          mask;
        shifted = tbl >> (idx * w);
        mask    = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return shifted[31:0] & mask;
    endfunction

endpackage

// File: rtl/ticket_vendor_if.sv
// Bus between the coin/selection front end, the vendor and the ejector drivers.
interface ticket_vendor_if #(
    parameter int N_TICKETS = 4,
    parameter int CREDIT_W  = 6
);
    localparam int SEL_W = (N_TICKETS > 1) ? $clog2(N_TICKETS) : 1;

    logic                          ci1;
    logic                          ci5;
    logic                          ci10;
    logic [SEL_W-1:0]              sel;
    logic                          sel_vld;
    logic                          cancel;
    logic [N_TICKETS*CREDIT_W-1:0] fee_tbl;

    logic [CREDIT_W-1:0]           credit;
    logic                          ticket;
    logic [SEL_W-1:0]              ticket_id;
    logic                          chg1;
    logic                          chg5;
    logic                          chg10;
    logic                          coin_rej;
    logic                          sel_err;
    logic                          busy;

    modport master (
        output ci1, ci5, ci10, sel, sel_vld, cancel, fee_tbl,
        input  credit, ticket, ticket_id, chg1, chg5, chg10, coin_rej, sel_err, busy
    );

    modport slave (
        input  ci1, ci5, ci10, sel, sel_vld, cancel, fee_tbl,
        output credit, ticket, ticket_id, chg1, chg5, chg10, coin_rej, sel_err, busy
    );

endinterface

// File: rtl/change_dispenser.sv
// Greedy coin-by-coin payout of a loaded amount: one 10/5/1 pulse per cycle.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                res,
    input  logic                load_i,
    input  logic [CREDIT_W-1:0] value_i,
    output logic                chg1_o,
    output logic                chg5_o,
    output logic                chg10_o,
    output logic                last_o,
    output logic                done_o
);

    logic [CREDIT_W-1:0] rem_q, rem_d;
    logic [CREDIT_W-1:0] rem_after;
    int                  coin_val;

    always_comb begin
        chg1_o   = 1'b0;
        chg5_o   = 1'b0;
        chg10_o  = 1'b0;
        coin_val = 0;
        // Compare as int so small CREDIT_W never truncates the denominations.
        if (32'(rem_q) >= 32'(COIN_10)) begin
            chg10_o  = 1'b1;
            coin_val = COIN_10;
        end else if (32'(rem_q) >= 32'(COIN_5)) begin
            chg5_o   = 1'b1;
            coin_val = COIN_5;
        end else if (rem_q != '0) begin
            chg1_o   = 1'b1;
            coin_val = COIN_1;
        end
    end

    assign rem_after = rem_q - CREDIT_W'(coin_val);
    assign rem_d     = load_i ? value_i : rem_after;
    assign last_o    = (rem_q != '0) && (rem_after == '0);
    assign done_o    = (rem_q == '0);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/ticket_vendor.sv
// Multi-ticket vending controller: collects coin credit, issues the pending
// ticket once credit covers its fee, and pays change/refunds via the dispenser.
module ticket_vendor
    import vend_pkg::*;
#(
    parameter int N_TICKETS   = 4,
    parameter int CREDIT_W    = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic            clk,
    input  logic            res,
    ticket_vendor_if.slave  bus
);

    localparam int SEL_W = (N_TICKETS > 1) ? $clog2(N_TICKETS) : 1;
    localparam int SUM_W = CREDIT_W + 5;
    localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [SUM_W-1:0] MAX_CREDIT = SUM_W'((64'd1 << CREDIT_W) - 64'd1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic [SUM_W-1:0]    coin_sum, credit_sum;
    logic [CREDIT_W-1:0] fee_sel, fee_pend;
    logic                coin_any, coin_fits, coin_ok;
    logic                sel_ok, activity, tmo_hit, purchase;

    logic                disp_load, disp_last, disp_done;
    logic [CREDIT_W-1:0] disp_val;
    logic                disp_chg1, disp_chg5, disp_chg10;

    // Out-of-range indices read as fee 0, which marks the selection invalid.
    assign fee_sel  = (32'(bus.sel) < 32'(N_TICKETS))
                    ? CREDIT_W'(fee_slice(TBL_MAX_W'(bus.fee_tbl), 32'(bus.sel), 32'(CREDIT_W)))
                    : '0;
    assign fee_pend = CREDIT_W'(fee_slice(TBL_MAX_W'(bus.fee_tbl), 32'(pend_q), 32'(CREDIT_W)));

    assign coin_any   = bus.ci1 | bus.ci5 | bus.ci10;
    assign coin_sum   = (bus.ci1  ? SUM_W'(COIN_1)  : '0)
                      + (bus.ci5  ? SUM_W'(COIN_5)  : '0)
                      + (bus.ci10 ? SUM_W'(COIN_10) : '0);
    assign credit_sum = SUM_W'(credit_q) + coin_sum;
    assign coin_fits  = (credit_sum <= MAX_CREDIT);
    assign sel_ok     = (fee_sel != '0);
    assign activity   = coin_any | bus.sel_vld | bus.cancel;
    assign tmo_hit    = (TIMEOUT_CYC != 0) && (32'(tmo_q) == 32'(TIMEOUT_CYC));
    assign purchase   = pend_vld_q && (credit_q >= fee_pend);

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        tmo_d      = tmo_q;
        coin_ok    = 1'b0;
        disp_load  = 1'b0;
        disp_val   = '0;

        unique case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (coin_any && coin_fits) begin
                    credit_d = credit_sum[CREDIT_W-1:0];
                    coin_ok  = 1'b1;
                    state_d  = S_COLLECT;
                end
                if (bus.sel_vld && sel_ok) begin
                    pend_d     = bus.sel;
                    pend_vld_d = 1'b1;
                    state_d    = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (coin_any && coin_fits) begin
                    credit_d = credit_sum[CREDIT_W-1:0];
                    coin_ok  = 1'b1;
                end
                // Any activity in the expiry cycle keeps the session alive.
                if (bus.cancel || (tmo_hit && !activity)) begin
                    disp_val   = credit_d;
                    credit_d   = '0;
                    pend_d     = '0;
                    pend_vld_d = 1'b0;
                    tmo_d      = '0;
                    if (disp_val != '0) begin
                        disp_load = 1'b1;
                        state_d   = S_DISPENSE;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else if (purchase) begin
                    // The selection being paid for is frozen; a new sel_vld is dropped.
                    state_d = S_VEND;
                end else begin
                    if (bus.sel_vld && sel_ok) begin
                        pend_d     = bus.sel;
                        pend_vld_d = 1'b1;
                    end
                    if (activity) begin
                        tmo_d = '0;
                    end else if (!tmo_hit && TIMEOUT_CYC != 0) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            S_VEND: begin
                disp_val   = credit_q - fee_pend;
                credit_d   = '0;
                pend_d     = '0;
                pend_vld_d = 1'b0;
                tmo_d      = '0;
                if (disp_val != '0) begin
                    disp_load = 1'b1;
                    state_d   = S_DISPENSE;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            S_DISPENSE: begin
                tmo_d = '0;
                if (disp_last || disp_done) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            tmo_q      <= tmo_d;
        end
    end

    change_dispenser #(
        .CREDIT_W (CREDIT_W)
    ) u_disp (
        .clk     (clk),
        .res     (res),
        .load_i  (disp_load),
        .value_i (disp_val),
        .chg1_o  (disp_chg1),
        .chg5_o  (disp_chg5),
        .chg10_o (disp_chg10),
        .last_o  (disp_last),
        .done_o  (disp_done)
    );

    // Input-driven pulses are masked so every output is 0 while reset is held.
    assign bus.credit    = credit_q;
    assign bus.ticket    = (state_q == S_VEND);
    assign bus.ticket_id = (state_q == S_VEND) ? pend_q : '0;
    assign bus.chg1      = disp_chg1;
    assign bus.chg5      = disp_chg5;
    assign bus.chg10     = disp_chg10;
    assign bus.coin_rej  = res & coin_any & ~coin_ok;
    assign bus.sel_err   = res & bus.sel_vld & ~sel_ok;
    assign bus.busy      = (state_q == S_VEND) || (state_q == S_DISPENSE);

endmodule

// File: tb/tb_ticket_vendor.sv
// Scoreboard bench for ticket_vendor: a session-level model predicts ticket and
// change events into a queue; a negedge monitor pops them as the DUT pulses.
module tb_ticket_vendor;

    localparam int N    = 4;
    localparam int CW   = 6;
    localparam int T    = 20;
    localparam int MAXC = 63;

    logic clk = 1'b0;
    logic res = 1'b0;

    ticket_vendor_if #(.N_TICKETS(N), .CREDIT_W(CW)) bus();

    ticket_vendor #(
        .N_TICKETS   (N),
        .CREDIT_W    (CW),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];          // 1/5/10 = change coin, 100+id = ticket
    int fees[N];

    // Model of the vendor at session level.
    int m_credit, m_pend, m_idle, m_busy, m_session;
    bit m_clr;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    endtask

    task automatic pack_fees();
        for (int i = 0; i < N; i++) bus.fee_tbl[i*CW +: CW] = CW'(fees[i]);
    endtask

    task automatic push_change(input int amt, output int n);
        n = 0;
        while (amt >= 10) begin exp_q.push_back(10); amt -= 10; n++; end
        while (amt >= 5)  begin exp_q.push_back(5);  amt -= 5;  n++; end
        while (amt >= 1)  begin exp_q.push_back(1);  amt -= 1;  n++; end
    endtask

    task automatic model_reset();
        m_credit = 0; m_pend = -1; m_idle = 0; m_busy = 0; m_session = 0; m_clr = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit c1, input bit c5, input bit c10,
                              input bit sv, input int s, input bit cn);
        int sum, newc, nc;
        bit anyc, act, sok, rej;
        anyc = c1 | c5 | c10;
        sum  = (c1 ? 1 : 0) + (c5 ? 5 : 0) + (c10 ? 10 : 0);
        sok  = (s < N) && (fees[s] != 0);
        act  = anyc | sv | cn;
        rej  = 1'b0;
        chk("sel_err", int'(bus.sel_err), int'(sv && !sok));
        chk("credit",  int'(bus.credit), m_credit);
        chk("busy",    int'(bus.busy), int'(m_busy > 0));
        if (m_busy > 0) begin
            rej = anyc;
            m_busy--;
            if (m_clr) begin m_credit = 0; m_clr = 0; end
        end else if (m_session == 0) begin
            if (anyc || (sv && sok)) begin
                m_session = 1; m_credit = sum; m_idle = 0;
                m_pend = (sv && sok) ? s : -1;
            end
        end else begin
            rej  = anyc && (m_credit + sum > MAXC);
            newc = rej ? m_credit : m_credit + sum;
            if (cn || (m_idle == T && !act)) begin
                push_change(newc, nc);
                m_busy = nc; m_credit = 0; m_pend = -1; m_session = 0;
            end else if (m_pend >= 0 && m_credit >= fees[m_pend]) begin
                exp_q.push_back(100 + m_pend);
                push_change(newc - fees[m_pend], nc);
                m_busy = 1 + nc; m_credit = newc; m_clr = 1; m_pend = -1; m_session = 0;
            end else begin
                m_credit = newc;
                if (sv && sok) m_pend = s;
                if (act) m_idle = 0;
                else if (m_idle < T) m_idle++;
            end
        end
        chk("coin_rej", int'(bus.coin_rej), int'(rej));
    endtask

    task automatic cycle(input bit c1, input bit c5, input bit c10,
                         input bit sv, input int s, input bit cn);
        @(posedge clk);
        #1;
        bus.ci1 = c1; bus.ci5 = c5; bus.ci10 = c10;
        bus.sel = s[1:0]; bus.sel_vld = sv; bus.cancel = cn;
        #3;
        model_step(c1, c5, c10, sv, s, cn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_inputs();
        bus.ci1 = 0; bus.ci5 = 0; bus.ci10 = 0;
        bus.sel = '0; bus.sel_vld = 0; bus.cancel = 0;
    endtask

    task automatic rand_phase(input int ncyc, input int pc, input int ps, input int pcn);
        for (int i = 0; i < ncyc; i++) begin
            cycle($urandom_range(0, 99) < pc, $urandom_range(0, 99) < pc,
                  $urandom_range(0, 99) < pc, $urandom_range(0, 99) < ps,
                  int'($urandom_range(0, N - 1)), $urandom_range(0, 99) < pcn);
        end
    endtask

    task automatic sb_pop(input string name, input int got);
        if (exp_q.size() == 0) chk({name, "_unexpected"}, got, 0);
        else chk(name, got, exp_q.pop_front());
    endtask

    // Event monitor
    initial begin
        forever begin
            @(negedge clk);
            if (res === 1'b1) begin
                int nch;
                nch = int'(bus.chg1) + int'(bus.chg5) + int'(bus.chg10);
                if (nch > 1) chk("chg_onehot", nch, 1);
                if (bus.ticket) sb_pop("ticket", 100 + int'(bus.ticket_id));
                if (nch == 1) sb_pop("change", bus.chg10 ? 10 : (bus.chg5 ? 5 : 1));
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fees = '{6, 3, 12, 15};
        pack_fees();
        clear_inputs();
        model_reset();

        #12;
        chk("rst_credit", int'(bus.credit), 0);
        chk("rst_busy",   int'(bus.busy), 0);
        chk("rst_ticket", int'(bus.ticket), 0);
        chk("rst_chg",    int'(bus.chg1) + int'(bus.chg5) + int'(bus.chg10), 0);
        chk("rst_rej",    int'(bus.coin_rej), 0);
        chk("rst_selerr", int'(bus.sel_err), 0);
        @(negedge clk) res = 1'b1;

        // Exact fee, no change
        cycle(0, 1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0, 0); cycle(0, 0, 0, 1, 0, 0); idle(4);
        // 20 paid for fee 6: change 10,1,1,1,1
        cycle(0, 0, 1, 0, 0, 0); cycle(0, 0, 1, 0, 0, 0); cycle(0, 0, 0, 1, 0, 0); idle(8);
        // Select first, pay afterwards: change 5,1,1
        cycle(0, 0, 0, 1, 1, 0); cycle(0, 0, 1, 0, 0, 0); idle(6);
        // Fill to 60, overflowing coin rejected, cancel refunds six 10s
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0, 1); idle(8);
        // Coin and cancel in the same cycle
        cycle(0, 0, 0, 1, 3, 0); cycle(0, 0, 1, 0, 0, 1); idle(3);
        // Zero-fee selection is an error
        fees[1] = 0; pack_fees();
        cycle(0, 0, 0, 1, 1, 0); idle(1);
        fees[1] = 3; pack_fees();
        // Timeouts with and without credit
        cycle(0, 1, 0, 0, 0, 0); idle(25);
        cycle(0, 0, 0, 1, 3, 0); idle(25);
        // Reset in the middle of a refund
        cycle(0, 0, 1, 0, 0, 0); cycle(0, 0, 1, 0, 0, 0); cycle(0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1 clear_inputs();
        #2 res = 1'b0;
        #1;
        chk("midrst_chg",    int'(bus.chg1) + int'(bus.chg5) + int'(bus.chg10), 0);
        chk("midrst_busy",   int'(bus.busy), 0);
        chk("midrst_credit", int'(bus.credit), 0);
        chk("midrst_ticket", int'(bus.ticket), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) res = 1'b1;
        idle(6);

        rand_phase(1500, 10, 8, 2);
        rand_phase(800, 15, 1, 1);
        rand_phase(1500, 2, 2, 1);

        idle(40);
        chk("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
